// File: rtl/painterengine_gpu_pkg.sv
// painterengine_gpu_pkg: shared state encodings, legal pixel sizes and the pixel shift helper.
package painterengine_gpu_pkg;
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CALC       = 3'd1,
        ST_WAIT_SPACE = 3'd2,
        ST_STREAM     = 3'd3,
        ST_CHECK      = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd7
    } state_e;

    localparam int BPP_1 = 1;
    localparam int BPP_2 = 2;
    localparam int BPP_4 = 4;

    function automatic int pix_shift(input int bpp);
        return (bpp == BPP_4) ? 2 : (bpp == BPP_2) ? 1 : 0;
    endfunction
endpackage

// File: rtl/painterengine_gpu_display_streamer_if.sv
// painterengine_gpu_display_streamer_if: burst request/response bus between streamer and DMA reader.
interface painterengine_gpu_display_streamer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] reader_address;
    logic [31:0]       reader_length;
    logic              reader_resetn;
    logic              reader_done;
    logic              reader_error;

    modport master(output reader_address, reader_length, reader_resetn, input reader_done, reader_error);
    modport slave(input reader_address, reader_length, reader_resetn, output reader_done, reader_error);
endinterface

// File: rtl/painterengine_gpu_burst_calc.sv
// painterengine_gpu_burst_calc: byte address and clipped pixel length of the next burst in a line.
module painterengine_gpu_burst_calc
    import painterengine_gpu_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int COORD_W         = 16,
    parameter int BURST_MAX       = 32,
    parameter int BYTES_PER_PIXEL = 4
) (
    input  logic [ADDR_W-1:0]  line_base_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] width_i,
    output logic [ADDR_W-1:0]  address_o,
    output logic [31:0]        length_o
);
    localparam int SHIFT = pix_shift(BYTES_PER_PIXEL);

    logic [COORD_W-1:0] rem;

    assign rem       = width_i - x_i;
    assign address_o = line_base_i + (ADDR_W'(x_i) << SHIFT);
    assign length_o  = (32'(rem) > 32'(BURST_MAX)) ? 32'(BURST_MAX) : 32'(rem);
endmodule

// File: rtl/painterengine_gpu_display_streamer.sv
// painterengine_gpu_display_streamer: streams a clipped framebuffer region as line bursts into the display FIFO.
// Optional PE_GPU_DISPLAY_STREAMER_DOUBLE_BUFFER_EN adds a shadow base address swapped in at frame restart.
module painterengine_gpu_display_streamer
    import painterengine_gpu_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int COORD_W         = 16,
    parameter int BURST_MAX       = 32,
    parameter int BYTES_PER_PIXEL = 4,
    parameter int FIFO_CNT_W      = 8
) (
    input  logic                  i_wire_clock,
    input  logic                  i_wire_reset,
    input  logic                  i_wire_start,
    input  logic                  i_wire_continuous,
    input  logic                  i_wire_frame_sync,
    input  logic [ADDR_W-1:0]     i_wire_image_address,
    input  logic [ADDR_W-1:0]     i_wire_line_stride,
    input  logic [COORD_W-1:0]    i_wire_clip_width,
    input  logic [COORD_W-1:0]    i_wire_clip_height,
    input  logic [FIFO_CNT_W-1:0] i_wire_fifo_free,
`ifdef PE_GPU_DISPLAY_STREAMER_DOUBLE_BUFFER_EN
    input  logic [ADDR_W-1:0]     i_wire_shadow_address,
    input  logic                  i_wire_shadow_valid,
    output logic                  o_wire_swap_ack,
`endif
    painterengine_gpu_display_streamer_if.master rd_if,
    output logic                  o_wire_busy,
    output logic                  o_wire_frame_done,
    output logic                  o_wire_error,
    output logic [2:0]            o_wire_state,
    output logic [COORD_W-1:0]    o_wire_line
);
    state_e              state_q, state_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d, width_q, width_d, height_q, height_d;
    logic [ADDR_W-1:0]   stride_q, stride_d, base_q, base_d, addr_q, addr_d, new_base, calc_addr;
    logic [31:0]         len_q, len_d, calc_len;
    logic                err_q, err_d, fdone_q, fdone_d, restart;

    painterengine_gpu_burst_calc #(
        .ADDR_W(ADDR_W), .COORD_W(COORD_W), .BURST_MAX(BURST_MAX), .BYTES_PER_PIXEL(BYTES_PER_PIXEL)
    ) u_calc (
        .line_base_i(base_q), .x_i(x_q), .width_i(width_q), .address_o(calc_addr), .length_o(calc_len)
    );

`ifdef PE_GPU_DISPLAY_STREAMER_DOUBLE_BUFFER_EN
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] shadow_q, shadow_d;

    always_comb begin
        pend_d   = restart ? 1'b0 : pend_q;
        shadow_d = shadow_q;
        if (i_wire_shadow_valid) begin
            pend_d   = 1'b1;
            shadow_d = i_wire_shadow_address;
        end
    end

    always_ff @(posedge i_wire_clock or posedge i_wire_reset)
        if (i_wire_reset) begin
            pend_q   <= 1'b0;
            shadow_q <= '0;
        end else begin
            pend_q   <= pend_d;
            shadow_q <= shadow_d;
        end

    assign new_base        = pend_q ? shadow_q : i_wire_image_address;
    assign o_wire_swap_ack = restart && pend_q;
`else
    assign new_base = i_wire_image_address;
`endif

    assign restart = (i_wire_start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR)) ||
                     (state_q == ST_DONE && i_wire_continuous && i_wire_frame_sync);

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        width_d  = width_q;
        height_d = height_q;
        stride_d = stride_q;
        base_d   = base_q;
        addr_d   = addr_q;
        len_d    = len_q;
        err_d    = err_q;
        case (state_q)
            ST_CALC: begin
                addr_d  = calc_addr;
                len_d   = calc_len;
                state_d = ST_WAIT_SPACE;
            end
            ST_WAIT_SPACE: state_d = (32'(i_wire_fifo_free) >= len_q) ? ST_STREAM : ST_WAIT_SPACE;
            ST_STREAM:
                if (rd_if.reader_error) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else if (rd_if.reader_done) begin
                    x_d     = x_q + COORD_W'(len_q);
                    state_d = ST_CHECK;
                end
            ST_CHECK:
                if (x_q == width_q) begin
                    x_d     = '0;
                    y_d     = y_q + COORD_W'(1);
                    base_d  = base_q + stride_q;
                    state_d = (y_d == height_q) ? ST_DONE : ST_CALC;
                end else begin
                    state_d = ST_CALC;
                end
            default: ;
        endcase
        if (restart) begin
            err_d    = 1'b0;
            x_d      = '0;
            y_d      = '0;
            width_d  = i_wire_clip_width;
            height_d = i_wire_clip_height;
            stride_d = i_wire_line_stride;
            base_d   = new_base;
            state_d  = (i_wire_clip_width == '0 || i_wire_clip_height == '0) ? ST_DONE : ST_CALC;
        end
        fdone_d = (state_d == ST_DONE) && (state_q != ST_DONE || restart);
    end

    always_ff @(posedge i_wire_clock or posedge i_wire_reset)
        if (i_wire_reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            width_q  <= '0;
            height_q <= '0;
            stride_q <= '0;
            base_q   <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            err_q    <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            width_q  <= width_d;
            height_q <= height_d;
            stride_q <= stride_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            err_q    <= err_d;
            fdone_q  <= fdone_d;
        end

    // Enable derives from the state register so an async reset kills it immediately.
    assign rd_if.reader_resetn  = (state_q == ST_STREAM);
    assign rd_if.reader_address = addr_q;
    assign rd_if.reader_length  = len_q;
    assign o_wire_busy          = (state_q == ST_CALC || state_q == ST_WAIT_SPACE ||
                                   state_q == ST_STREAM || state_q == ST_CHECK);
    assign o_wire_frame_done    = fdone_q;
    assign o_wire_error         = err_q;
    assign o_wire_state         = state_q;
    assign o_wire_line          = y_q;
endmodule

// File: tb/tb_painterengine_gpu_display_streamer.sv
// tb_painterengine_gpu_display_streamer: directed checks of burst sequencing, gating, errors and restart.
module tb_painterengine_gpu_display_streamer;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cont = 1'b0, sync = 1'b0;
    logic [31:0] base = 32'h1000, stride = 32'h200;
    logic [15:0] w = 16'd70, h = 16'd2;
    logic [7:0]  fifo = 8'd255;
    logic        busy, fdone, err;
    logic [2:0]  state;
    logic [15:0] line;
    int          n_cmp = 0, n_bad = 0;
`ifdef PE_GPU_DISPLAY_STREAMER_DOUBLE_BUFFER_EN
    logic [31:0] sh_addr = '0;
    logic        sh_vld = 1'b0, swap_ack;
`endif

    painterengine_gpu_display_streamer_if #(.ADDR_W(32)) rd_if ();

    painterengine_gpu_display_streamer dut (
        .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_start(start), .i_wire_continuous(cont),
        .i_wire_frame_sync(sync), .i_wire_image_address(base), .i_wire_line_stride(stride),
        .i_wire_clip_width(w), .i_wire_clip_height(h), .i_wire_fifo_free(fifo),
`ifdef PE_GPU_DISPLAY_STREAMER_DOUBLE_BUFFER_EN
        .i_wire_shadow_address(sh_addr), .i_wire_shadow_valid(sh_vld), .o_wire_swap_ack(swap_ack),
`endif
        .rd_if(rd_if), .o_wire_busy(busy), .o_wire_frame_done(fdone), .o_wire_error(err),
        .o_wire_state(state), .o_wire_line(line)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rd();
        int n = 0;
        while (!rd_if.reader_resetn && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_resetn", rd_if.reader_resetn, 1);
    endtask

    task automatic burst(input logic [31:0] ea, input logic [31:0] el, input logic [15:0] ey, input logic e);
        wait_rd();
        chk("addr", rd_if.reader_address, ea);
        chk("len", rd_if.reader_length, el);
        chk("line", line, ey);
        rd_if.reader_done  = 1'b1;
        rd_if.reader_error = e;
        @(negedge clk);
        rd_if.reader_done  = 1'b0;
        rd_if.reader_error = 1'b0;
    endtask

    task automatic frame70x2();
        burst(32'h1000, 32, 0, 0);
        burst(32'h1080, 32, 0, 0);
        burst(32'h1100, 6, 0, 0);
        burst(32'h1200, 32, 1, 0);
        burst(32'h1280, 32, 1, 0);
        burst(32'h1300, 6, 1, 0);
    endtask

    task automatic wait_fdone();
        int n = 0;
        while (!fdone && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("frame_done", fdone, 1);
        chk("done_state", state, 5);
        @(negedge clk);
        chk("frame_done_pulse", fdone, 0);
    endtask

    initial begin
        rd_if.reader_done  = 1'b0;
        rd_if.reader_error = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_resetn", rd_if.reader_resetn, 0);
        chk("rst_addr", rd_if.reader_address, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fdone", fdone, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        chk("calc_state", state, 1);
        chk("calc_busy", busy, 1);
        frame70x2();
        wait_fdone();
        // FIFO gating, then a simultaneous done+error on burst 2
        fifo = 8'd20;
        pulse_start();
        @(negedge clk);
        chk("wait_state", state, 2);
        repeat (3) @(negedge clk);
        chk("wait_hold", state, 2);
        chk("wait_resetn", rd_if.reader_resetn, 0);
        fifo = 8'd32;
        @(negedge clk);
        chk("space_state", state, 3);
        chk("space_resetn", rd_if.reader_resetn, 1);
        fifo = 8'd255;
        burst(32'h1000, 32, 0, 0);
        burst(32'h1080, 32, 0, 1);
        chk("err_state", state, 7);
        chk("err_resetn", rd_if.reader_resetn, 0);
        chk("err_flag", err, 1);
        repeat (2) @(negedge clk);
        chk("err_sticky", state, 7);
        pulse_start();
        chk("err_clear", err, 0);
        chk("err_restart", state, 1);
        frame70x2();
        wait_fdone();
        // zero-size frames
        w = 16'd0;
        pulse_start();
        chk("w0_state", state, 5);
        chk("w0_fdone", fdone, 1);
        chk("w0_resetn", rd_if.reader_resetn, 0);
        @(negedge clk);
        chk("w0_pulse", fdone, 0);
        w = 16'd70;
        h = 16'd0;
        pulse_start();
        chk("h0_state", state, 5);
        chk("h0_fdone", fdone, 1);
        @(negedge clk);
        chk("h0_pulse", fdone, 0);
        // continuous re-arm on frame sync
        h = 16'd1;
        cont = 1'b1;
        pulse_start();
        burst(32'h1000, 32, 0, 0);
        burst(32'h1080, 32, 0, 0);
        burst(32'h1100, 6, 0, 0);
        wait_fdone();
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk("sync_restart", state, 1);
        chk("sync_line", line, 0);
        wait_rd();
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk("sync_ignored", state, 3);
        burst(32'h1000, 32, 0, 0);
        burst(32'h1080, 32, 0, 0);
        burst(32'h1100, 6, 0, 0);
        wait_fdone();
        cont = 1'b0;
        // async reset while streaming
        h = 16'd2;
        pulse_start();
        wait_rd();
        #2 rst = 1'b1;
        #1;
        chk("arst_resetn", rd_if.reader_resetn, 0);
        chk("arst_state", state, 0);
        chk("arst_addr", rd_if.reader_address, 0);
        chk("arst_len", rd_if.reader_length, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_idle", rd_if.reader_resetn, 0);
`ifdef PE_GPU_DISPLAY_STREAMER_DOUBLE_BUFFER_EN
        sh_addr = 32'h8000;
        sh_vld  = 1'b1;
        @(negedge clk);
        sh_vld = 1'b0;
        start  = 1'b1;
        #1;
        chk("swap_ack", swap_ack, 1);
        @(negedge clk);
        start = 1'b0;
        chk("swap_ack_pulse", swap_ack, 0);
        burst(32'h8000, 32, 0, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/painterengine_gpu_display_streamer.md
Name: painterengine_gpu_display_streamer

Overview:
Parametrised successor to the single-mode display reader controller. Fetches a clipped framebuffer region line-by-line as DMA read bursts into the display FIFO. Adds a generic pixel size, an independent line stride, a configurable burst size, FIFO-space gating and continuous frame re-arm on a frame-sync pulse. Sits between the register file/DMA reader and the pixel FIFO feeding the DVI timing block.

Parameters:
ADDR_W, 32, byte address width.
COORD_W, 16, width of the x/y/clip counters.
BURST_MAX, 32, maximum pixels per reader burst (1..2^FIFO_CNT_W-1).
BYTES_PER_PIXEL, 4, pixel size in bytes; legal values are 1, 2 or 4.
FIFO_CNT_W, 8, width of the FIFO free-count input.

Ports:
i_wire_clock  in  1  system clock.
i_wire_reset  in  1  asynchronous, active-high reset.
i_wire_start  in  1  one-cycle pulse: begin a frame from IDLE/DONE/ERROR.
i_wire_continuous  in  1  1 = re-arm on frame sync after each frame.
i_wire_frame_sync  in  1  one-cycle pulse from the DVI block at frame start.
i_wire_image_address  in  ADDR_W  framebuffer base (byte).
i_wire_line_stride  in  ADDR_W  bytes between line starts.
i_wire_clip_width  in  COORD_W  pixels per line.
i_wire_clip_height  in  COORD_W  lines per frame.
i_wire_fifo_free  in  FIFO_CNT_W  free FIFO entries.
o_wire_reader_address  out  ADDR_W  burst byte address.
o_wire_reader_length  out  32  burst length in pixels.
o_wire_reader_resetn  out  1  0 = reader held idle; 1 = run burst.
i_wire_reader_done  in  1  burst complete.
i_wire_reader_error  in  1  burst failed.
o_wire_busy  out  1  high in CALC/WAIT_SPACE/STREAM/CHECK.
o_wire_frame_done  out  1  one-cycle pulse on DONE entry.
o_wire_error  out  1  sticky error flag.
o_wire_state  out  3  current state encoding.
o_wire_line  out  COORD_W  current y.

Behaviour:
- Reset (async, i_wire_reset=1): state IDLE; all outputs 0; x=y=0; line_base=0.
- States: IDLE=0, CALC=1, WAIT_SPACE=2, STREAM=3, CHECK=4, DONE=5, ERROR=7.
- IDLE: reader_resetn=0. On start: if width==0 or height==0, go to DONE (frame_done pulses the next cycle, no bursts issued); else latch width/height/stride, line_base=image_address, x=y=0, go to CALC.
- CALC (1 cycle): address=line_base + x*BYTES_PER_PIXEL (shift, no multiplier); length=min(BURST_MAX, width-x). Then go to WAIT_SPACE.
- WAIT_SPACE: hold while fifo_free < length. On fifo_free >= length go to STREAM. reader_resetn rises on the first STREAM cycle.
- STREAM: reader_resetn=1; address and length are stable. If error and done arrive in the same cycle, error wins: go to ERROR and drive reader_resetn=0. On done: x+=length, reader_resetn=0, go to CHECK.
- CHECK (1 cycle): if x==width, set x=0, y+=1, line_base+=stride (mod 2^ADDR_W); if the new y==height go to DONE, else go to CALC. Otherwise go to CALC.
- DONE: reader_resetn=0. With continuous=1, a frame_sync pulse reloads all parameters from the inputs and restarts exactly as start does. A start pulse always restarts.
- ERROR: o_wire_error=1, reader_resetn=0. Only start (clears error, restarts) or reset leaves this state.
- start while busy: ignored. frame_sync outside DONE: ignored.
- Inputs are sampled only at frame restart; changes mid-frame take effect on the next frame.
- Reset mid-burst: reader_resetn drops asynchronously and no further bursts are issued.

Optional Feature:
PE_GPU_DISPLAY_STREAMER_DOUBLE_BUFFER_EN
- With the macro: adds i_wire_shadow_address (ADDR_W), i_wire_shadow_valid (pulse) and o_wire_swap_ack (pulse).
  - shadow_valid latches a pending address; the last pulse before restart wins.
  - At the next frame restart the pending address replaces image_address as line_base and swap_ack pulses in that cycle.
  - The pending flag clears on restart.
- Without the macro: these ports are absent and image_address is used directly at every restart.

Decomposition:
- Shared package painterengine_gpu_pkg: state encodings, legal BYTES_PER_PIXEL values, log2 helper for the pixel shift.
- One natural sub-module, painterengine_gpu_burst_calc: combinational address/length computation (line_base, x, width -> address, length), reused by future layer readers.

Test Plan:
- base=0x1000, stride=0x200, width=70, height=2, BURST_MAX=32, bpp=4, fifo_free=255 -> bursts (0x1000,32), (0x1080,32), (0x1100,6), (0x1200,32), (0x1280,32), (0x1300,6); then frame_done pulses once and the state is DONE.
- fifo_free=20 with length 32 -> holds in WAIT_SPACE with reader_resetn=0; raising fifo_free to 32 -> STREAM next cycle.
- Error during burst 2 (simultaneous with done) -> ERROR, reader_resetn=0, error=1, x unchanged; a start pulse clears error and restarts at 0x1000.
- width=0 -> frame_done one cycle after start, zero bursts; height=0 -> same.
- continuous=1 -> after DONE, a frame_sync pulse restarts at base with y=0; a frame_sync during STREAM is ignored.
- Reset asserted mid-STREAM -> reader_resetn=0 in the same cycle, all outputs 0; with the double-buffer macro, a shadow 0x8000 is applied at the next restart and swap_ack pulses once.
